// File: rtl/config_write_arbiter.sv
// config_write_arbiter
//   Shares the eFPGA configuration word-write port between two bitstream sources.
//   Source 0 is the USB DFU path, source 1 the UART/bitbang path. The first source to
//   present a word owns the port for a whole session; the session ends on the owner's end
//   pulse or after TIMEOUT_CYCLES idle cycles. Words from the non-owner are discarded and
//   recorded in a sticky per-source drop flag.
// Ports
//   clk_i                in   rising-edge system clock
//   reset_n_i            in   asynchronous active-low reset
//   s0_strobe_i/_data_i  in   source 0 word strobe (1-cycle pulse) and 32-bit word
//   s0_end_i             in   source 0 end-of-session pulse
//   s1_strobe_i/_data_i  in   source 1 word strobe and word
//   s1_end_i             in   source 1 end-of-session pulse
//   clear_drop_i         in   clears both drop flags (a simultaneous new drop wins)
//   word_write_strobe_o  out  forwarded strobe, one cycle after the accepted input strobe
//   write_data_o         out  forwarded word, held while the strobe is low
//   grant_o              out  one-hot owner {s1, s0}; 2'b00 when idle
//   s0_dropped_o         out  sticky: a source 0 word was discarded
//   s1_dropped_o         out  sticky: a source 1 word was discarded
//   timeout_o            out  one-cycle pulse when a grant is released by timeout
module config_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W          = 17
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        s0_strobe_i,
  input  logic [31:0] s0_data_i,
  input  logic        s0_end_i,
  input  logic        s1_strobe_i,
  input  logic [31:0] s1_data_i,
  input  logic        s1_end_i,
  input  logic        clear_drop_i,
  output logic        word_write_strobe_o,
  output logic [31:0] write_data_o,
  output logic [1:0]  grant_o,
  output logic        s0_dropped_o,
  output logic        s1_dropped_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  // Counter value at which an idle owner loses the port on the next cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic              last_grant_r;
  logic              last_grant_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              fwd_s;
  logic [31:0]       fwd_data_s;
  logic              set0_s;
  logic              set1_s;
  logic              timeout_s;

  logic              strobe_r;
  logic [31:0]       data_r;
  logic              s0_drop_r;
  logic              s1_drop_r;
  logic              timeout_r;

  // Next-state, forwarding, drop and timeout decisions for the current cycle.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    fwd_s        = 1'b0;
    fwd_data_s   = 32'h0000_0000;
    set0_s       = 1'b0;
    set1_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (s0_strobe_i && s1_strobe_i) begin
          // Tie: the source that did not own the port last time wins.
          fwd_s = 1'b1;
          if (last_grant_r) begin
            state_s      = ST_GRANT0;
            last_grant_s = 1'b0;
            fwd_data_s   = s0_data_i;
            set1_s       = 1'b1;
          end else begin
            state_s      = ST_GRANT1;
            last_grant_s = 1'b1;
            fwd_data_s   = s1_data_i;
            set0_s       = 1'b1;
          end
        end else if (s0_strobe_i) begin
          state_s      = ST_GRANT0;
          last_grant_s = 1'b0;
          fwd_s        = 1'b1;
          fwd_data_s   = s0_data_i;
        end else if (s1_strobe_i) begin
          state_s      = ST_GRANT1;
          last_grant_s = 1'b1;
          fwd_s        = 1'b1;
          fwd_data_s   = s1_data_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        set1_s = s1_strobe_i;
        if (s0_strobe_i) begin
          // An owner word beats both the end pulse and the timeout.
          fwd_s      = 1'b1;
          fwd_data_s = s0_data_i;
          cnt_s      = CNT_ZERO;
          if (s0_end_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_GRANT0;
          end
        end else if (s0_end_i) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_IDLE;
          cnt_s     = CNT_ZERO;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GRANT1: begin
        set0_s = s0_strobe_i;
        if (s1_strobe_i) begin
          fwd_s      = 1'b1;
          fwd_data_s = s1_data_i;
          cnt_s      = CNT_ZERO;
          if (s1_end_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_GRANT1;
          end
        end else if (s1_end_i) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_IDLE;
          cnt_s     = CNT_ZERO;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, arbitration history and idle counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= CNT_ZERO;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
    end
  end

  // Registered forwarding path; the data register only loads on an accepted word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      strobe_r <= 1'b0;
      data_r   <= 32'h0000_0000;
    end else begin
      strobe_r <= fwd_s;
      if (fwd_s) begin
        data_r <= fwd_data_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Sticky drop flags (set beats clear) and the timeout pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s0_drop_r <= 1'b0;
      s1_drop_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      s0_drop_r <= set0_s | (s0_drop_r & ~clear_drop_i);
      s1_drop_r <= set1_s | (s1_drop_r & ~clear_drop_i);
      timeout_r <= timeout_s;
    end
  end

  assign word_write_strobe_o = strobe_r;
  assign write_data_o        = data_r;
  assign grant_o             = {state_r == ST_GRANT1, state_r == ST_GRANT0};
  assign s0_dropped_o        = s0_drop_r;
  assign s1_dropped_o        = s1_drop_r;
  assign timeout_o           = timeout_r;

endmodule
